bcdbinary_seq: RTL

Sequential packed-BCD to binary converter; the inverse of the team's binary-to-BCD adjust logic. Accepts a DIGITS-digit packed BCD word over a valid/ready handshake, converts it with a reverse double-dabble loop (shift right, then subtract 3 from every BCD digit that is ≥8), and presents the binary result on a second valid/ready handshake. It sits between BCD-domain front ends (keypads, display registers) and the binary datapath.

---
 rtl/bcdbinary_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bcdbinary_seq.sv
// Sequential packed-BCD to binary converter using a reverse double-dabble loop.
// Optional macro BCDBIN_ERRCHK_EN: flag and short-circuit words with nibbles above 9.
module bcdbinary_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [BCD_W-1:0]   shift_bcd;
  logic [BIN_W-1:0]   shift_bin;

  // A shifted digit >= 8 picked up a 1 from the digit above (worth 5 here, not 8).
  function automatic logic [BCD_W-1:0] adjust_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i+3]) begin
        r[4*i +: 4] = r[4*i +: 4] - 4'd3;
      end
    end
    return r;
  endfunction

`ifdef BCDBIN_ERRCHK_EN
  logic err_q, err_d;

  function automatic logic has_bad_nibble(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction
`endif

  assign {shift_bcd, shift_bin} = {bcd_q, bin_q} >> 1;

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef BCDBIN_ERRCHK_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_d      = bcd_in;
          bin_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          in_ready_d = 1'b0;
          state_d    = CONV;
`ifdef BCDBIN_ERRCHK_EN
          err_d      = 1'b0;
          if (has_bad_nibble(bcd_in)) begin
            bcd_d       = '0;
            cnt_d       = '0;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
`endif
        end
      end
      CONV: begin
        bcd_d = adjust_digits(shift_bcd);
        bin_d = shift_bin;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef BCDBIN_ERRCHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef BCDBIN_ERRCHK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
`ifdef BCDBIN_ERRCHK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
